// File: rtl/param_counter_if.sv
// Handshake bundle between a param_counter and whatever drives it.
// Latency: none (wires only).
// Backpressure: none; the counter accepts every control input on every edge.
//
// master: drives control/compare inputs, observes count/tc/cmp_match.
// slave : the counter side.
interface param_counter_if #(
  parameter int WIDTH = 16
);
  logic             en;
  logic             up_dn;
  logic             clear;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] cmp_val;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             cmp_match;

  modport master (
    output en, up_dn, clear, load, load_val, cmp_val,
    input  count, tc, cmp_match
  );

  modport slave (
    input  en, up_dn, clear, load, load_val, cmp_val,
    output count, tc, cmp_match
  );
endinterface

// File: rtl/param_counter.sv
// Parametrised up/down event counter with terminal value, wrap/saturate, clear, load and compare.
// Latency: count/tc update one edge after inputs are sampled; cmp_match is combinational from count.
// Backpressure: none; every edge consumes the current control inputs.
//
// Ports: clock, resetN (synchronous, active-low); bus (param_counter_if.slave):
//   en, up_dn, clear, load, load_val, cmp_val in; count, tc, cmp_match out.
// Optional macro PARAM_COUNTER_PRESCALE_EN: adds a prescaler so one count step
//   happens every PRESCALE enabled cycles.
module param_counter #(
  parameter int              WIDTH    = 16,
  parameter longint unsigned MAX_VAL  = (64'd1 << WIDTH) - 64'd1,
  parameter int              SATURATE = 0,
  parameter int              PRESCALE = 4
) (
  input  logic             clock,
  input  logic             resetN,
  param_counter_if.slave   bus
);

  localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_VAL);

  // Reject configurations the counter cannot represent.
  if (WIDTH < 2 || WIDTH > 32 || MAX_VAL < 64'd1 ||
      MAX_VAL > ((64'd1 << WIDTH) - 64'd1) || PRESCALE < 1) begin : g_bad_params
    $error("param_counter: illegal parameter combination");
  end

  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;
  logic             step;

`ifdef PARAM_COUNTER_PRESCALE_EN
  // One extra bit is kept for PRESCALE=1 so the vector is never zero-width;
  // it simply stays at 0 and every enabled cycle becomes a step.
  localparam int          PW         = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] presc_q, presc_d;

  always_comb begin
    presc_d = presc_q;
    step    = 1'b0;
    if (bus.clear || bus.load) begin
      presc_d = '0;
    end else if (bus.en) begin
      if (presc_q == PRESC_LAST) begin
        presc_d = '0;
        step    = 1'b1;
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!resetN) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end
`else
  assign step = bus.en;
`endif

  // Terminal checks happen on the current value before any +/-1, so the
  // arithmetic never needs a carry bit.
  always_comb begin
    count_d = count_q;
    tc_d    = 1'b0;
    if (bus.clear) begin
      count_d = '0;
    end else if (bus.load) begin
      count_d = (bus.load_val > MAX_W) ? MAX_W : bus.load_val;
    end else if (step) begin
      if (bus.up_dn) begin
        if (count_q == MAX_W) begin
          tc_d    = 1'b1;
          count_d = (SATURATE != 0) ? MAX_W : '0;
        end else begin
          count_d = count_q + WIDTH'(1);
        end
      end else begin
        if (count_q == '0) begin
          tc_d    = 1'b1;
          count_d = (SATURATE != 0) ? '0 : MAX_W;
        end else begin
          count_d = count_q - WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!resetN) begin
      count_q <= '0;
      tc_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
    end
  end

  assign bus.count     = count_q;
  assign bus.tc        = tc_q;
  assign bus.cmp_match = (count_q == bus.cmp_val);

endmodule

// File: tb/tb_param_counter.sv
// Bench for param_counter: four instances (16-bit free range, 4-bit wrap at 9,
// 4-bit saturate at 9, 4-bit with PRESCALE=4) driven by directed steps and then
// random traffic, all compared each edge against a behavioural model.
module tb_param_counter;

`ifdef PARAM_COUNTER_PRESCALE_EN
  localparam int PS3 = 4;
`else
  localparam int PS3 = 1;
`endif

  logic clock;
  logic resetN;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Per-instance stimulus
  logic        s_en  [4];
  logic        s_up  [4];
  logic        s_clr [4];
  logic        s_ld  [4];
  logic [15:0] s_ldv [4];
  logic [15:0] s_cmp [4];

  param_counter_if #(.WIDTH(16)) if0 ();
  param_counter_if #(.WIDTH(4))  if1 ();
  param_counter_if #(.WIDTH(4))  if2 ();
  param_counter_if #(.WIDTH(4))  if3 ();

  assign if0.en = s_en[0];  assign if0.up_dn = s_up[0];  assign if0.clear = s_clr[0];
  assign if0.load = s_ld[0]; assign if0.load_val = s_ldv[0]; assign if0.cmp_val = s_cmp[0];
  assign if1.en = s_en[1];  assign if1.up_dn = s_up[1];  assign if1.clear = s_clr[1];
  assign if1.load = s_ld[1]; assign if1.load_val = s_ldv[1][3:0]; assign if1.cmp_val = s_cmp[1][3:0];
  assign if2.en = s_en[2];  assign if2.up_dn = s_up[2];  assign if2.clear = s_clr[2];
  assign if2.load = s_ld[2]; assign if2.load_val = s_ldv[2][3:0]; assign if2.cmp_val = s_cmp[2][3:0];
  assign if3.en = s_en[3];  assign if3.up_dn = s_up[3];  assign if3.clear = s_clr[3];
  assign if3.load = s_ld[3]; assign if3.load_val = s_ldv[3][3:0]; assign if3.cmp_val = s_cmp[3][3:0];

  param_counter #(.WIDTH(16), .PRESCALE(1))
    u0 (.clock(clock), .resetN(resetN), .bus(if0));
  param_counter #(.WIDTH(4), .MAX_VAL(9), .SATURATE(0), .PRESCALE(1))
    u1 (.clock(clock), .resetN(resetN), .bus(if1));
  param_counter #(.WIDTH(4), .MAX_VAL(9), .SATURATE(1), .PRESCALE(1))
    u2 (.clock(clock), .resetN(resetN), .bus(if2));
  param_counter #(.WIDTH(4), .PRESCALE(4))
    u3 (.clock(clock), .resetN(resetN), .bus(if3));

  // Reference model: plain integer state per instance
  longint m_cnt  [4];
  bit     m_tc   [4];
  int     m_pc   [4];
  longint m_max  [4] = '{65535, 9, 9, 15};
  longint m_mask [4] = '{65535, 15, 15, 15};
  bit     m_sat  [4] = '{0, 0, 1, 0};
  int     m_ps   [4] = '{1, 1, 1, PS3};

  int n_checks = 0;
  int n_errors = 0;

  int seq3 [4] = '{1, 0, 0, 0};
  int tc3  [4] = '{0, 0, 1, 1};

  function automatic logic [63:0] get_cnt(int d);
    case (d)
      0:       return 64'(if0.count);
      1:       return 64'(if1.count);
      2:       return 64'(if2.count);
      default: return 64'(if3.count);
    endcase
  endfunction

  function automatic logic [63:0] get_tc(int d);
    case (d)
      0:       return 64'(if0.tc);
      1:       return 64'(if1.tc);
      2:       return 64'(if2.tc);
      default: return 64'(if3.tc);
    endcase
  endfunction

  function automatic logic [63:0] get_cmp(int d);
    case (d)
      0:       return 64'(if0.cmp_match);
      1:       return 64'(if1.cmp_match);
      2:       return 64'(if2.cmp_match);
      default: return 64'(if3.cmp_match);
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input longint exp);
    n_checks++;
    assert (obs === 64'(exp)) else begin
      n_errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance every model by one rising edge using the inputs present at it.
  task automatic model_edge();
    longint ldv;
    for (int d = 0; d < 4; d++) begin
      ldv = longint'(s_ldv[d]) & m_mask[d];
      if (!resetN) begin
        m_cnt[d] = 0; m_tc[d] = 0; m_pc[d] = 0;
      end else if (s_clr[d]) begin
        m_cnt[d] = 0; m_tc[d] = 0; m_pc[d] = 0;
      end else if (s_ld[d]) begin
        m_cnt[d] = (ldv > m_max[d]) ? m_max[d] : ldv;
        m_tc[d] = 0; m_pc[d] = 0;
      end else if (s_en[d]) begin
        m_tc[d] = 0;
        m_pc[d]++;
        if (m_pc[d] == m_ps[d]) begin
          m_pc[d] = 0;
          if (s_up[d]) begin
            if (m_cnt[d] == m_max[d]) begin
              m_tc[d] = 1;
              if (!m_sat[d]) m_cnt[d] = 0;
            end else m_cnt[d]++;
          end else begin
            if (m_cnt[d] == 0) begin
              m_tc[d] = 1;
              if (!m_sat[d]) m_cnt[d] = m_max[d];
            end else m_cnt[d]--;
          end
        end
      end else begin
        m_tc[d] = 0;
      end
    end
  endtask

  task automatic check_all();
    for (int d = 0; d < 4; d++) begin
      chk($sformatf("count%0d", d), get_cnt(d), m_cnt[d]);
      chk($sformatf("tc%0d", d), get_tc(d), longint'(m_tc[d]));
      chk($sformatf("cmp_match%0d", d), get_cmp(d),
          longint'(m_cnt[d] == (longint'(s_cmp[d]) & m_mask[d])));
    end
  endtask

  task automatic tick();
    @(posedge clock);
    model_edge();
    #1;
    check_all();
  endtask

  initial begin
    for (int d = 0; d < 4; d++) begin
      s_en[d] = 1'b1; s_up[d] = 1'b1; s_clr[d] = 1'b0; s_ld[d] = 1'b0;
      s_ldv[d] = '0;  s_cmp[d] = 16'hFFFF;
      m_cnt[d] = 0;   m_tc[d] = 0; m_pc[d] = 0;
    end
    resetN = 1'b0;

    // 1: reset held over two enabled edges, then five counting edges
    tick(); tick();
    chk("t1_reset_count", get_cnt(0), 0);
    chk("t1_reset_tc", get_tc(0), 0);
    resetN = 1'b1;
    repeat (5) tick();
    chk("t1_count5", get_cnt(0), 5);

    // 2: wrap at 9 on instance 1
    s_clr[1] = 1'b1; tick(); s_clr[1] = 1'b0;
    repeat (10) tick();
    chk("t2_wrap_count", get_cnt(1), 0);
    chk("t2_wrap_tc", get_tc(1), 1);
    tick();
    chk("t2_after_count", get_cnt(1), 1);
    chk("t2_after_tc", get_tc(1), 0);

    // 3: saturate going down on instance 2
    s_ld[2] = 1'b1; s_ldv[2] = 16'd2; tick();
    s_ld[2] = 1'b0; s_up[2] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t3_seq", get_cnt(2), seq3[i]);
      chk("t3_tc", get_tc(2), tc3[i]);
    end

    // 4: load clamp and priority on instance 1
    s_ld[1] = 1'b1; s_ldv[1] = 16'd12; tick();
    chk("t4_clamp", get_cnt(1), 9);
    s_clr[1] = 1'b1; tick();
    chk("t4_clear_wins", get_cnt(1), 0);
    s_clr[1] = 1'b0; s_ldv[1] = 16'd5; tick();
    chk("t4_load_no_step", get_cnt(1), 5);
    s_ld[1] = 1'b0;

    // 5: compare and a reset pulse that never meets an edge
    s_cmp[0] = 16'd7; s_ld[0] = 1'b1; s_ldv[0] = 16'd5; tick();
    s_ld[0] = 1'b0;
    tick(); tick();
    chk("t5_match7", get_cmp(0), 1);
    tick();
    chk("t5_nomatch8", get_cmp(0), 0);
    #2 resetN = 1'b0;
    #2;
    chk("t5_async_count", get_cnt(0), 8);
    chk("t5_async_tc", get_tc(0), longint'(m_tc[0]));
    resetN = 1'b1;
    tick();
    chk("t5_resume", get_cnt(0), 9);

    // 6: prescaled instance 3
    s_clr[3] = 1'b1; tick(); s_clr[3] = 1'b0;
    repeat (12) tick();
    chk("t6_count12", get_cnt(3), (PS3 == 4) ? 3 : 12);
    s_clr[3] = 1'b1; tick(); s_clr[3] = 1'b0;
    repeat (2) tick();
    s_en[3] = 1'b0;
    repeat (3) tick();
    s_en[3] = 1'b1;
    tick();
    chk("t6_delayed_pre", get_cnt(3), (PS3 == 4) ? 0 : 3);
    tick();
    chk("t6_delayed_step", get_cnt(3), (PS3 == 4) ? 1 : 4);

    // Mid-count reset with load active
    s_ld[0] = 1'b1; s_ldv[0] = 16'd100; resetN = 1'b0; tick();
    chk("mid_reset_count", get_cnt(0), 0);
    resetN = 1'b1; s_ld[0] = 1'b0; tick();
    chk("mid_reset_resume", get_cnt(0), 1);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      for (int d = 0; d < 4; d++) begin
        s_en[d]  = ($urandom_range(0, 3) != 0);
        s_up[d]  = ((n / 40) % 2 == 0) ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 7) == 0);
        s_clr[d] = ($urandom_range(0, 29) == 0);
        s_ld[d]  = ($urandom_range(0, 14) == 0);
        s_ldv[d] = 16'($urandom);
        s_cmp[d] = (d == 0) ? 16'($urandom_range(0, 20)) : 16'($urandom_range(0, 15));
      end
      resetN = ($urandom_range(0, 59) != 0);
      tick();
    end

    resetN = 1'b1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/param_counter.md
Name: param_counter

Overview:
- Parametrised successor to the team's free-running 16-bit counter.
- Adds a programmable terminal value, up/down direction, wrap or saturate mode, synchronous clear and load, enable, and a compare-match output.
- Used as the general event/timebase counter in testbenches and small control blocks.
- Single clock domain. All state changes on the rising edge of clock.

Parameters:
- WIDTH, 16, counter width in bits (2..32).
- MAX_VAL, 2**WIDTH-1, terminal count. Counter range is 0..MAX_VAL inclusive. Must be ≥1 and ≤2**WIDTH-1.
- SATURATE, 0, terminal behaviour: 0 = wrap, 1 = hold at terminal.
- PRESCALE, 4, enabled cycles per count step (≥1). Used only when PARAM_COUNTER_PRESCALE_EN is defined.

Ports:
- clock, input, 1, rising-edge clock.
- resetN, input, 1, reset; synchronous, active-low.
- en, input, 1, count enable.
- up_dn, input, 1, direction: 1 = up, 0 = down.
- clear, input, 1, synchronous clear to 0.
- load, input, 1, synchronous load of load_val.
- load_val, input, WIDTH, value to load.
- cmp_val, input, WIDTH, compare value.
- count, output, WIDTH, current count (registered).
- tc, output, 1, terminal-count event pulse (registered).
- cmp_match, output, 1, count == cmp_val (combinational from the count register).

Behaviour:
- Reset
  - resetN is sampled only on a rising clock edge. Asynchronous assertion has no effect until the next edge.
  - An edge with resetN=0 sets count=0 and tc=0.
  - Before the first edge with resetN=0, count is undefined (X in simulation). The bench must hold resetN low across at least one rising edge before checking outputs.
- Per-edge priority, highest first: reset > clear > load > count step (en) > hold.
  - clear=1: count <= 0; tc <= 0.
  - load=1: count <= min(load_val, MAX_VAL); tc <= 0. Loads above MAX_VAL clamp to MAX_VAL.
  - en=1, up_dn=1, count<MAX_VAL: count <= count+1.
  - en=1, up_dn=1, count==MAX_VAL: count <= 0 if SATURATE=0, else it holds MAX_VAL. tc <= 1 in both modes.
  - en=1, up_dn=0, count>0: count <= count-1.
  - en=1, up_dn=0, count==0: count <= MAX_VAL if SATURATE=0, else it holds 0. tc <= 1 in both modes.
  - en=0: count holds; tc <= 0.
- tc timing
  - tc is high for exactly one cycle, in the cycle after the terminal step.
  - tc stays high on consecutive cycles while saturated with en=1.
- Latency
  - count updates 1 cycle after the controlling input is sampled.
  - cmp_match follows count with 0 cycles of additional latency.
- Arithmetic
  - Unsigned, WIDTH bits. No intermediate overflow: the terminal compare happens before the increment.
- Direction change: up_dn may change on any cycle and takes effect on the same edge. No glitch or extra step.
- Simultaneous events: clear+load, or load+en, follow the priority order above. No step is taken in a cycle where load or clear wins.
- Mid-count reset: the next edge with resetN=0 forces count=0 and tc=0 regardless of other inputs. Counting resumes on the first edge after resetN returns to 1.

Optional Feature:
- Macro: PARAM_COUNTER_PRESCALE_EN.
- Defined:
  - An internal prescaler (ceil(log2(PRESCALE)) bits, reset and cleared to 0) counts enabled cycles.
  - A count step occurs only on the enabled cycle where the prescaler equals PRESCALE-1; the prescaler then returns to 0.
  - en=0 freezes the prescaler.
  - load and clear also zero the prescaler.
  - With PRESCALE=1, behaviour is identical to the macro being undefined.
- Undefined: no prescaler logic; every enabled cycle is a count step.

Test Plan:
1. Reset, WIDTH=16: hold resetN=0 for 2 edges with en=1 -> count=0, tc=0. Release resetN, 5 enabled edges -> count=5.
2. Wrap up, WIDTH=4, MAX_VAL=9, SATURATE=0: from 0, 10 enabled edges -> count=0 and tc=1 for exactly one cycle. Edge 11 -> count=1, tc=0.
3. Saturate down, MAX_VAL=9, SATURATE=1: load 2, up_dn=0, 4 enabled edges -> count sequence 1, 0, 0, 0; tc=1 on the last two cycles.
4. Load and priority: load_val=12, MAX_VAL=9 -> count=9. Same edge with clear=1, load=1, en=1 -> count=0. load=1 with en=1 -> count=load_val and no step.
5. Compare: cmp_val=7, count up from 5 -> cmp_match=1 only while count=7. Async resetN pulse between edges -> no change until the next edge.
6. With PARAM_COUNTER_PRESCALE_EN, PRESCALE=4: 12 enabled edges -> count=3. en dropped for 3 cycles mid-period -> step delayed by exactly 3 cycles.
